lcd_bus_writer: RTL and testbench
=================================

// Module: lcd_bus_writer
// PURPOSE
//  Downstream stage of the LCD printer path. Drains the 17-bit write FIFO that the printer and
//  init sequencer fill, and drives the panel's 8080-style 16-bit parallel write bus (CS/RS/WR/RD).
//  Word bit16 selects command (0) or pixel/parameter data (1); bits15:0 are the bus value.
//  Also generates the panel hardware-reset pulse at power-up and holds all writes until it completes.
// PARAMETERS
//  WR_LOW_CYC    2        clk cycles LCD_WR is held low per transfer (>=1)
//  WR_HIGH_CYC   2        clk cycles LCD_WR is held high after each transfer (>=1)
//  RST_LOW_CYC   500      clk cycles LCD_RST is held low after rst_n release (>=1)
//  RST_WAIT_CYC  6000000  clk cycles waited after LCD_RST rises before the first write (>=1)
//  CNT_W         24       width of the shared timing counter; must hold max(parameters)-1
// PORTS
//  clk       in   1   system clock (FIFO read-side clock)
//  rst_n     in   1   asynchronous active-low reset
//  rempty    in   1   FIFO empty; rdata is valid whenever rempty=0 (first-word-fall-through)
//  rdata     in   17  FIFO head word: [16]=RS value, [15:0]=bus data
//  rinc      out  1   FIFO pop, one-cycle pulse, only when rempty=0
//  LCD_CS    out  1   panel chip select, active low
//  LCD_RS    out  1   register select: 0=command, 1=data
//  LCD_WR    out  1   write strobe, active low; panel latches on rising edge
//  LCD_RD    out  1   read strobe, tied inactive (1)
//  LCD_RST   out  1   panel hardware reset, active low
//  LCD_DATA  out  16  parallel data bus
//  ready     out  1   1 once the power-up reset/wait sequence has completed
// BEHAVIOUR
//  All LCD_* outputs and ready are registered; rinc is combinational from state and rempty.
//  Reset values: LCD_CS=1 LCD_WR=1 LCD_RD=1 LCD_RS=0 LCD_DATA=0 LCD_RST=0 ready=0 rinc=0,
//    state=RST_LOW, counter=0.
//  States:
//   RST_LOW : LCD_RST=0. Counts RST_LOW_CYC cycles, then LCD_RST<=1, counter<=0, go to RST_WAIT.
//   RST_WAIT: counts RST_WAIT_CYC cycles, then ready<=1, go to IDLE. FIFO is never popped in
//             RST_LOW/RST_WAIT, regardless of rempty.
//   IDLE    : LCD_CS=1, LCD_WR=1. If rempty=0: rinc=1 this cycle; LCD_DATA<=rdata[15:0],
//             LCD_RS<=rdata[16], LCD_CS<=0, LCD_WR<=0, counter<=0, go to WR_LO.
//   WR_LO   : LCD_WR stays 0 for WR_LOW_CYC cycles total; then LCD_WR<=1, counter<=0, go to WR_HI.
//   WR_HI   : data/RS/CS held stable for WR_HIGH_CYC cycles total. On the last cycle:
//             rempty=0 -> back-to-back: rinc=1, load next word, LCD_WR<=0, CS stays 0, go to WR_LO;
//             rempty=1 -> LCD_CS<=1, go to IDLE.
//  Timing: from IDLE, the first LCD_WR falling edge is 1 clk after the pop cycle. A back-to-back
//    burst has a period of WR_LOW_CYC+WR_HIGH_CYC clks per word; an isolated word takes
//    1+WR_LOW_CYC+WR_HIGH_CYC clks from pop to CS release.
//  LCD_DATA/LCD_RS change only on the same edge that drives LCD_WR low, never while LCD_WR=0,
//    so data is stable from the falling edge through the rising (latch) edge plus WR_HIGH_CYC.
//  Exactly one rinc pulse per LCD_WR low pulse; words are written in FIFO order, none dropped.
//  The FIFO going empty during WR_LO/WR_HI has no effect until the decision cycle of WR_HI.
//  Counter compares use (count == PARAM-1); the counter never wraps in legal configurations.
//  Reset mid-transfer: all outputs return to their reset values asynchronously, including
//    LCD_RST=0. The popped word in flight is discarded. The full RST_LOW/RST_WAIT sequence
//    re-runs before any further write.
// TESTING
//  1 Power-up, small params (RST_LOW=4, RST_WAIT=6), FIFO preloaded -> LCD_RST low 4 clk,
//    ready rises 6 clk later, no rinc before ready=1.
//  2 Single word 0x0002A (cmd) in IDLE -> rinc 1 clk; then CS=0, RS=0, DATA=0x002A,
//    WR low 2 clk, high 2 clk, then CS=1.
//  3 Burst 0x0002C,0x1F800,0x107E0,0x1001F preloaded -> 4 WR pulses, period 4 clk, CS low
//    throughout, RS 0,1,1,1, DATA order preserved, 4 rinc pulses.
//  4 FIFO empties mid-burst, then a word arrives 10 clk later -> CS returns high, IDLE;
//    new word written with correct RS/DATA, no duplicate or skipped word.
//  5 rst_n asserted while LCD_WR=0 -> outputs immediately at reset values; after release the
//    reset sequence repeats and the next FIFO word (not the lost one) is written.
//  6 Scoreboard: 1000 random words, random rempty gaps -> panel-side capture on LCD_WR rising
//    edges equals the FIFO input stream. Check per pulse: WR low exactly WR_LOW_CYC, DATA stable.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// Drains a FWFT 17-bit word FIFO onto an 8080-style 16-bit panel write bus after a power-up panel reset.
// Pop-to-WR-fall is 1 clk; the FIFO is popped only once the panel bus is free, and never while empty.
module lcd_bus_writer #(
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RST_LOW_CYC  = 500,
  parameter int RST_WAIT_CYC = 6000000,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rempty,
  input  logic [16:0] rdata,
  output logic        rinc,
  output logic        LCD_CS,
  output logic        LCD_RS,
  output logic        LCD_WR,
  output logic        LCD_RD,
  output logic        LCD_RST,
  output logic [15:0] LCD_DATA,
  output logic        ready
);

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_IDLE,
    S_WR_LO,
    S_WR_HI
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LO_LAST    = CNT_W'(WR_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] WR_HI_LAST    = CNT_W'(WR_HIGH_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             cs_q;
  logic             rs_q;
  logic             wr_q;
  logic             lcd_rst_q;
  logic [15:0]      data_q;
  logic             ready_q;
  logic             hi_last;

  assign cnt_d   = cnt_q + 1'b1;
  assign hi_last = (state_q == S_WR_HI) && (cnt_q == WR_HI_LAST);

  // Pop in the same cycle the word is loaded onto the bus, so there is one pop per WR pulse.
  assign rinc = !rempty && ((state_q == S_IDLE) || hi_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST_LOW;
      cnt_q     <= '0;
      cs_q      <= 1'b1;
      rs_q      <= 1'b0;
      wr_q      <= 1'b1;
      lcd_rst_q <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_RST_LOW: begin
          if (cnt_q == RST_LOW_LAST) begin
            lcd_rst_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_RST_WAIT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RST_WAIT: begin
          if (cnt_q == RST_WAIT_LAST) begin
            ready_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_IDLE: begin
          cs_q <= 1'b1;
          wr_q <= 1'b1;
          if (rinc) begin
            data_q  <= rdata[15:0];
            rs_q    <= rdata[16];
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          if (cnt_q == WR_LO_LAST) begin
            wr_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_WR_HI;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WR_HI: begin
          if (hi_last) begin
            cnt_q <= '0;
            if (rinc) begin
              data_q  <= rdata[15:0];
              rs_q    <= rdata[16];
              wr_q    <= 1'b0;
              state_q <= S_WR_LO;
            end else begin
              cs_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_RST_LOW;
      endcase
    end
  end

  assign LCD_CS   = cs_q;
  assign LCD_RS   = rs_q;
  assign LCD_WR   = wr_q;
  assign LCD_RD   = 1'b1;
  assign LCD_RST  = lcd_rst_q;
  assign LCD_DATA = data_q;
  assign ready    = ready_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed and randomised bench for lcd_bus_writer with a FWFT FIFO model and a panel-side capture.
module tb_lcd_bus_writer;
  localparam int WRL  = 2;
  localparam int WRH  = 2;
  localparam int RSTL = 4;
  localparam int RSTW = 6;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold  = 1'b1;
  logic        rempty;
  logic [16:0] rdata;
  logic        rinc;
  logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, ready;
  logic [15:0] LCD_DATA;

  logic [16:0] mem [0:4095];
  int          wp = 0;
  int          rp = 0;
  int          pops = 0;
  int          bad_pop = 0;

  logic [16:0] cap [0:2047];
  time         cap_t [0:2047];
  int          cap_n = 0;
  int          lo_run = 0;
  logic [16:0] lo_dat;
  int          bad_w = 0;
  int          unstable = 0;

  int errors = 0;
  int checks = 0;

  lcd_bus_writer #(
    .WR_LOW_CYC(WRL), .WR_HIGH_CYC(WRH), .RST_LOW_CYC(RSTL), .RST_WAIT_CYC(RSTW), .CNT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
    .LCD_RST(LCD_RST), .LCD_DATA(LCD_DATA), .ready(ready)
  );

  always #5 clk = ~clk;

  assign rempty = (wp == rp) || hold;
  assign rdata  = mem[rp[11:0]];

  always @(posedge clk) begin
    if (rinc === 1'b1) begin
      if (rempty) bad_pop++;
      rp <= rp + 1;
      pops++;
    end
  end

  // Panel latches on the WR rising edge; edges caused by reset are not writes.
  always @(posedge LCD_WR) begin
    if (rst_n === 1'b1) begin
      cap[cap_n[10:0]]   = {LCD_RS, LCD_DATA};
      cap_t[cap_n[10:0]] = $time;
      cap_n++;
    end
  end

  always @(negedge clk) begin
    if (LCD_WR === 1'b0) begin
      if (lo_run > 0 && {LCD_RS, LCD_DATA} !== lo_dat) unstable++;
      lo_dat = {LCD_RS, LCD_DATA};
      lo_run++;
    end else begin
      if (lo_run > 0 && rst_n === 1'b1 && lo_run != WRL) bad_w++;
      lo_run = 0;
    end
  end

  task automatic push(input logic [16:0] w);
    mem[wp[11:0]] = w;
    wp = wp + 1;
  endtask

  task automatic test_reset();
    int rr = 0;
    int rd = 0;
    int early = 0;
    rst_n = 1'b0;
    hold  = 1'b0;
    push(17'h0002A);
    repeat (2) @(negedge clk);
    checks++; if (LCD_CS !== 1'b1) begin errors++; $display("FAIL reset_cs: got %b want 1", LCD_CS); end
    checks++; if (LCD_WR !== 1'b1) begin errors++; $display("FAIL reset_wr: got %b want 1", LCD_WR); end
    checks++; if (LCD_RD !== 1'b1) begin errors++; $display("FAIL reset_rd: got %b want 1", LCD_RD); end
    checks++; if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", LCD_RS); end
    checks++; if (LCD_DATA !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", LCD_DATA); end
    checks++; if (LCD_RST !== 1'b0) begin errors++; $display("FAIL reset_lcdrst: got %b want 0", LCD_RST); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 40 && rd == 0; i++) begin
      @(negedge clk);
      if (LCD_RST === 1'b1 && rr == 0) rr = i;
      if (ready === 1'b1) rd = i;
      else if (rinc === 1'b1) early++;
    end
    checks++; if (rr != RSTL) begin errors++; $display("FAIL rst_low_len: got %0d want %0d", rr, RSTL); end
    checks++; if (rd - rr != RSTW) begin errors++; $display("FAIL rst_wait_len: got %0d want %0d", rd - rr, RSTW); end
    checks++; if (early != 0) begin errors++; $display("FAIL early_rinc: got %0d want 0", early); end
  endtask

  task automatic test_single();
    logic [2:0] exp_seq [0:5];
    logic [2:0] obs;
    int p0 = pops;
    int c0 = cap_n;
    exp_seq = '{3'b111, 3'b000, 3'b000, 3'b010, 3'b010, 3'b110};
    for (int j = 0; j < 6; j++) begin
      if (j > 0) @(negedge clk);
      obs = {LCD_CS, LCD_WR, rinc};
      checks++;
      if (obs !== exp_seq[j]) begin
        errors++; $display("FAIL single_step%0d {cs,wr,rinc}: got %b want %b", j, obs, exp_seq[j]);
      end
      if (j == 1) begin
        checks++;
        if ({LCD_RS, LCD_DATA} !== 17'h0002A) begin
          errors++; $display("FAIL single_bus: got %h want 0002a", {LCD_RS, LCD_DATA});
        end
      end
    end
    checks++; if (pops - p0 != 1) begin errors++; $display("FAIL single_pops: got %0d want 1", pops - p0); end
    checks++;
    if (cap_n - c0 != 1 || cap[c0[10:0]] !== 17'h0002A) begin
      errors++; $display("FAIL single_capture: got n=%0d w=%h want n=1 w=0002a", cap_n - c0, cap[c0[10:0]]);
    end
  endtask

  task automatic test_burst();
    logic [16:0] w [0:3];
    int p0, c0;
    int cs_hi = 0;
    int bad_per = 0;
    int bad_dat = 0;
    w = '{17'h0002C, 17'h1F800, 17'h107E0, 17'h1001F};
    hold = 1'b1;
    for (int k = 0; k < 4; k++) push(w[k]);
    p0 = pops;
    c0 = cap_n;
    @(negedge clk);
    hold = 1'b0;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (j <= 16 && LCD_CS !== 1'b0) cs_hi++;
    end
    checks++; if (cs_hi != 0) begin errors++; $display("FAIL burst_cs_low: got %0d high cycles want 0", cs_hi); end
    checks++; if (LCD_CS !== 1'b1) begin errors++; $display("FAIL burst_cs_release: got %b want 1", LCD_CS); end
    checks++; if (pops - p0 != 4) begin errors++; $display("FAIL burst_pops: got %0d want 4", pops - p0); end
    checks++; if (cap_n - c0 != 4) begin errors++; $display("FAIL burst_count: got %0d want 4", cap_n - c0); end
    for (int k = 0; k < 4; k++) begin
      if (cap[(c0 + k) % 2048] !== w[k]) bad_dat++;
      if (k > 0 && cap_t[(c0 + k) % 2048] - cap_t[(c0 + k - 1) % 2048] != 40) bad_per++;
    end
    checks++; if (bad_dat != 0) begin errors++; $display("FAIL burst_data: got %0d wrong words want 0", bad_dat); end
    checks++; if (bad_per != 0) begin errors++; $display("FAIL burst_period: got %0d wrong periods want 0", bad_per); end
  endtask

  task automatic test_gap();
    logic [16:0] w [0:2];
    int p0, c0;
    int bad_dat = 0;
    w = '{17'h11234, 17'h000B0, 17'h1ABCD};
    hold = 1'b1;
    push(w[0]);
    push(w[1]);
    p0 = pops;
    c0 = cap_n;
    @(negedge clk);
    hold = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (LCD_CS !== 1'b1) begin errors++; $display("FAIL gap_cs_idle: got %b want 1", LCD_CS); end
    repeat (10) @(negedge clk);
    checks++;
    if ({LCD_CS, LCD_WR, rinc} !== 3'b110) begin
      errors++; $display("FAIL gap_idle_quiet {cs,wr,rinc}: got %b want 110", {LCD_CS, LCD_WR, rinc});
    end
    push(w[2]);
    repeat (7) @(negedge clk);
    checks++; if (pops - p0 != 3) begin errors++; $display("FAIL gap_pops: got %0d want 3", pops - p0); end
    checks++; if (cap_n - c0 != 3) begin errors++; $display("FAIL gap_count: got %0d want 3", cap_n - c0); end
    for (int k = 0; k < 3; k++) if (cap[(c0 + k) % 2048] !== w[k]) bad_dat++;
    checks++; if (bad_dat != 0) begin errors++; $display("FAIL gap_data: got %0d wrong words want 0", bad_dat); end
  endtask

  task automatic test_reset_mid();
    int c0;
    int got_rdy = 0;
    hold = 1'b1;
    push(17'h00051);
    push(17'h15A5A);
    c0 = cap_n;
    @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    checks++; if (LCD_WR !== 1'b0) begin errors++; $display("FAIL mid_wr_low: got %b want 0", LCD_WR); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({LCD_CS, LCD_WR, LCD_RST, ready, LCD_RS, LCD_DATA} !== {4'b1100, 17'h0}) begin
      errors++; $display("FAIL mid_async_reset {cs,wr,rst,ready,rs,data}: got %b_%h want 1100_00000",
                         {LCD_CS, LCD_WR, LCD_RST, ready}, {LCD_RS, LCD_DATA});
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 40 && got_rdy == 0; i++) begin
      @(negedge clk);
      if (ready === 1'b1) got_rdy = 1;
    end
    checks++; if (got_rdy != 1) begin errors++; $display("FAIL mid_ready_timeout: got %0d want 1", got_rdy); end
    checks++; if (cap_n != c0) begin errors++; $display("FAIL mid_no_write_in_reset: got %0d want 0", cap_n - c0); end
    repeat (7) @(negedge clk);
    checks++;
    if (cap_n - c0 != 1 || cap[c0[10:0]] !== 17'h15A5A) begin
      errors++; $display("FAIL mid_next_word: got n=%0d w=%h want n=1 w=15a5a", cap_n - c0, cap[c0[10:0]]);
    end
  endtask

  task automatic test_scoreboard();
    int p0 = pops;
    int c0 = cap_n;
    int base = wp;
    int bw0 = bad_w;
    int un0 = unstable;
    int bp0 = bad_pop;
    int mism = 0;
    hold = 1'b1;
    for (int i = 0; i < 1000; i++) push(17'($urandom_range(0, 17'h1FFFF)));
    for (int cyc = 0; cyc < 20000 && pops - p0 < 1000; cyc++) begin
      @(negedge clk);
      hold = ($urandom_range(0, 3) == 0);
    end
    hold = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (pops - p0 != 1000) begin errors++; $display("FAIL sb_pops: got %0d want 1000", pops - p0); end
    checks++; if (cap_n - c0 != 1000) begin errors++; $display("FAIL sb_count: got %0d want 1000", cap_n - c0); end
    for (int k = 0; k < 1000; k++) if (cap[(c0 + k) % 2048] !== mem[(base + k) % 4096]) mism++;
    checks++; if (mism != 0) begin errors++; $display("FAIL sb_data: got %0d mismatched words want 0", mism); end
    checks++; if (bad_w != bw0) begin errors++; $display("FAIL sb_wr_width: got %0d bad pulses want 0", bad_w - bw0); end
    checks++; if (unstable != un0) begin errors++; $display("FAIL sb_data_stable: got %0d changes want 0", unstable - un0); end
    checks++; if (bad_pop != bp0) begin errors++; $display("FAIL sb_pop_empty: got %0d want 0", bad_pop - bp0); end
    checks++; if (LCD_CS !== 1'b1) begin errors++; $display("FAIL sb_cs_release: got %b want 1", LCD_CS); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_gap();
    test_reset_mid();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
